alt_seq_tx: RTL and testbench
=============================

ALT_SEQ_TX -- requirements
Module: alt_seq_tx

Interface
REQ-001 Parameter: LW, default 4, width of the length input and the internal bit counter.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-004 Port: start  input  1  request to begin one burst; honoured only in IDLE.
REQ-005 Port: len  input  LW  number of serial bits in the burst; sampled with start.
REQ-006 Port: phase  input  1  value of the first emitted bit; sampled with start.
REQ-007 Port: pause  input  1  stall request; freezes transmission while high in SEND.
REQ-008 Port: x  output  1  serial alternating bit stream (drives a detector's x input).
REQ-009 Port: valid  output  1  high when x carries a new bit this cycle.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  one-cycle pulse at burst end.
REQ-012 Port: sent  output  LW  count of bits emitted in current or most recent burst.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, SEND, DONE; state register, next-state logic and output logic kept separate.
REQ-014 IDLE: start=1 and len!=0 -> SEND next cycle; len and phase latched; sent cleared to 0.
REQ-015 IDLE: start=1 and len==0 -> DONE next cycle, no bit emitted, sent cleared to 0.
REQ-016 IDLE: start=0 -> remain IDLE; x, valid, done held 0; sent holds last value.
REQ-017 SEND, pause=0: valid=1; x = latched phase XOR sent[0] (first bit = phase, then strict alternation); sent increments by 1 at clock edge.
REQ-018 SEND, pause=1: valid=0; x holds last emitted value (phase before first bit); sent and state unchanged.
REQ-019 SEND: when the bit being emitted is the last (sent == len-1, pause=0) -> DONE next cycle.
REQ-020 Latency: first valid bit appears in the cycle immediately after start accepted; burst of N bits with no pause occupies exactly N SEND cycles.
REQ-021 DONE: done=1, valid=0, busy=1, x=0 for exactly one cycle; unconditional transition to IDLE.
REQ-022 start asserted in SEND or DONE SHALL be ignored (not queued); len/phase changes in SEND/DONE have no effect.
REQ-023 sent SHALL never wrap: maximum value len (max 2^LW-1).
REQ-024 x, valid, done SHALL be functions of state and latched registers only (Moore outputs), except pause gating of valid per REQ-018.
REQ-025 Unused state encodings SHALL return to IDLE on next clock.

Reset
REQ-026 reset=1 at posedge clk -> state IDLE; x=0, valid=0, busy=0, done=0, sent=0, latched len/phase=0.
REQ-027 reset has priority over start and pause in the same cycle.
REQ-028 reset mid-burst (SEND or DONE) aborts immediately; no done pulse generated.
REQ-029 Outputs undefined before first reset edge; bench SHALL apply reset for at least 2 cycles.

Verification
REQ-030 start=1, len=4, phase=0, pause=0 -> x=0,1,0,1 with valid=1 on 4 consecutive cycles, then done=1 one cycle, sent=4, busy low next.
REQ-031 start=1, len=3, phase=1, pause high on 2nd SEND cycle for 2 cycles -> x=1, (hold 1, valid=0) x2, then 0,1; done after 5 SEND cycles; sent=3.
REQ-032 start=1, len=0 -> no valid cycle; done=1 on next cycle; sent=0.
REQ-033 start pulsed again during SEND of len=5 burst -> burst unaffected, exactly 5 bits, no second burst.
REQ-034 reset asserted after 2 bits of len=6 burst -> next cycle all outputs 0, state IDLE, done never pulses.
REQ-035 Loopback: x/valid-gated clock into the alternating-sequence detector, len=5, phase=0 -> detector flags found after the 3rd and following bits.

Source files
------------

// File: rtl/alt_seq_tx.sv
// Alternating-bit burst transmitter: emits len bits starting at phase, stalls on pause,
// then pulses done for one cycle before returning to idle.
module alt_seq_tx #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          phase,
  input  logic          pause,
  output logic          x,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] sent_q, sent_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      sent_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      phase_q <= phase_d;
    end
  end

  // sent cannot wrap: it only advances while below the latched length, which is at least 1 in SEND.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sent_d  = sent_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          phase_d = phase;
          sent_d  = '0;
          state_d = (len == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (!pause) begin
          sent_d = sent_q + 1'b1;
          if (sent_d == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While paused, x repeats the previously emitted bit, or phase if nothing has gone out yet.
  always_comb begin
    x     = 1'b0;
    valid = 1'b0;
    done  = 1'b0;
    busy  = (state_q != IDLE);
    case (state_q)
      SEND: begin
        valid = !pause;
        if (!pause)               x = phase_q ^ sent_q[0];
        else if (sent_q == '0)    x = phase_q;
        else                      x = ~(phase_q ^ sent_q[0]);
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sent = sent_q;

endmodule

// File: tb/tb_alt_seq_tx.sv
// Self-checking bench for alt_seq_tx: directed scenarios plus randomized bursts
// compared against a bit-index reference model and a behavioural alternation detector.
module tb_alt_seq_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] len;
  logic       phase;
  logic       pause;
  logic       x;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] sent;

  int vectors     = 0;
  int miscompares = 0;

  alt_seq_tx #(.LW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .phase (phase),
    .pause (pause),
    .x     (x),
    .valid (valid),
    .busy  (busy),
    .done  (done),
    .sent  (sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {x, valid, busy, done, sent[3:0]}
  function automatic logic [7:0] mk(logic ex, logic ev, logic eb, logic ed, logic [3:0] es);
    return {ex, ev, eb, ed, es};
  endfunction

  task automatic test_reset();
    logic [7:0] obs;
    reset = 1'b1; start = 1'b1; pause = 1'b1; len = 4'd5; phase = 1'b1;
    repeat (3) @(negedge clk);
    #1 obs = {x, valid, busy, done, sent};
    vectors++;
    if (obs !== mk(0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got %b want %b", obs, mk(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; pause = 1'b0;
    #1 obs = {x, valid, busy, done, sent};
    vectors++;
    if (obs !== mk(0, 0, 0, 0, 0)) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got %b want %b", obs, mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_basic();
    logic [7:0] obs, ex;
    @(negedge clk);
    start = 1'b1; len = 4'd4; phase = 1'b0; pause = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1 obs = {x, valid, busy, done, sent};
      if (i < 4)       ex = mk(i[0], 1, 1, 0, 4'(i));
      else if (i == 4) ex = mk(0, 0, 1, 1, 4'd4);
      else             ex = mk(0, 0, 0, 0, 4'd4);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL basic_len4 cycle %0d: got %b want %b", i, obs, ex);
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] obs;
    logic       pauseTab [7] = '{0, 1, 1, 0, 0, 0, 0};
    logic [7:0] expTab   [7];
    expTab[0] = mk(1, 1, 1, 0, 4'd0);
    expTab[1] = mk(1, 0, 1, 0, 4'd1);
    expTab[2] = mk(1, 0, 1, 0, 4'd1);
    expTab[3] = mk(0, 1, 1, 0, 4'd1);
    expTab[4] = mk(1, 1, 1, 0, 4'd2);
    expTab[5] = mk(0, 0, 1, 1, 4'd3);
    expTab[6] = mk(0, 0, 0, 0, 4'd3);
    @(negedge clk);
    start = 1'b1; len = 4'd3; phase = 1'b1; pause = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      pause = pauseTab[i];
      #1 obs = {x, valid, busy, done, sent};
      vectors++;
      if (obs !== expTab[i]) begin
        miscompares++;
        $display("[TB] FAIL pause_len3 cycle %0d: got %b want %b", i, obs, expTab[i]);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [7:0] obs, ex;
    @(negedge clk);
    start = 1'b1; len = 4'd0; phase = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1 obs = {x, valid, busy, done, sent};
      ex = (i == 0) ? mk(0, 0, 1, 1, 4'd0) : mk(0, 0, 0, 0, 4'd0);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL zero_len cycle %0d: got %b want %b", i, obs, ex);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [7:0] obs, ex;
    @(negedge clk);
    start = 1'b1; len = 4'd5; phase = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = (i < 6);
      len   = 4'd2;
      phase = 1'b1;
      #1 obs = {x, valid, busy, done, sent};
      if (i < 5)       ex = mk(i[0], 1, 1, 0, 4'(i));
      else if (i == 5) ex = mk(0, 0, 1, 1, 4'd5);
      else             ex = mk(0, 0, 0, 0, 4'd5);
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL start_ignored cycle %0d: got %b want %b", i, obs, ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] obs, ex;
    @(negedge clk);
    start = 1'b1; len = 4'd6; phase = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1 obs = {x, valid, busy, done, sent};
      ex = mk(~i[0], 1, 1, 0, 4'(i));
      vectors++;
      if (obs !== ex) begin
        miscompares++;
        $display("[TB] FAIL reset_mid bit %0d: got %b want %b", i, obs, ex);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 obs = {x, valid, busy, done, sent};
      vectors++;
      if (obs !== mk(0, 0, 0, 0, 0)) begin
        miscompares++;
        $display("[TB] FAIL reset_mid after %0d: got %b want %b", i, obs, mk(0, 0, 0, 0, 0));
      end
      @(negedge clk);
    end
  endtask

  // Detector model: found once the last three or more valid bits strictly alternate.
  task automatic test_loopback();
    int   run = 0;
    int   bitIdx = 0;
    logic prev = 1'b0;
    logic found;
    @(negedge clk);
    start = 1'b1; len = 4'd5; phase = 1'b0;
    for (int cyc = 0; cyc < 12 && bitIdx < 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (valid === 1'b1) begin
        run = (run > 0 && x !== prev) ? run + 1 : 1;
        prev = x;
        bitIdx++;
        found = (run >= 3);
        vectors++;
        if (found !== (bitIdx >= 3)) begin
          miscompares++;
          $display("[TB] FAIL loopback bit %0d: found got %b want %b", bitIdx, found, bitIdx >= 3);
        end
      end
    end
    vectors++;
    if (bitIdx != 5) begin
      miscompares++;
      $display("[TB] FAIL loopback_count: got %0d bits want 5", bitIdx);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] obs, ex;
    logic [3:0] bLen;
    logic       bPhase, last, pz;
    logic [3:0] modelSent;
    int         k;
    bit         finished;
    modelSent = sent;
    for (int b = 0; b < 40; b++) begin
      @(negedge clk);
      bLen   = 4'($urandom_range(0, 15));
      bPhase = 1'($urandom);
      start = 1'b1; len = bLen; phase = bPhase; pause = 1'b0;
      #1 obs = {x, valid, busy, done, sent};
      vectors++;
      if (obs !== mk(0, 0, 0, 0, modelSent)) begin
        miscompares++;
        $display("[TB] FAIL rand_idle burst %0d: got %b want %b", b, obs, mk(0, 0, 0, 0, modelSent));
      end
      k = 0; last = bPhase; finished = 0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
        @(negedge clk);
        start = 1'($urandom);
        len   = 4'($urandom);
        phase = 1'($urandom);
        pz    = ($urandom_range(0, 2) == 0);
        pause = pz;
        #1 obs = {x, valid, busy, done, sent};
        if (k == int'(bLen)) begin
          ex = mk(0, 0, 1, 1, bLen);
          finished = 1;
        end else if (pz) begin
          ex = mk(last, 0, 1, 0, 4'(k));
        end else begin
          ex = mk(bPhase ^ k[0], 1, 1, 0, 4'(k));
          last = bPhase ^ k[0];
          k++;
        end
        vectors++;
        if (obs !== ex) begin
          miscompares++;
          $display("[TB] FAIL rand burst %0d len %0d cycle %0d: got %b want %b", b, bLen, cyc, obs, ex);
        end
      end
      if (!finished) begin
        miscompares++;
        $display("[TB] FAIL rand_timeout burst %0d: got no done want done", b);
      end
      start = 1'b0; pause = 1'b0;
      modelSent = bLen;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; phase = 1'b0; pause = 1'b0;
    test_reset();
    test_basic();
    test_pause();
    test_zero_len();
    test_start_ignored();
    test_reset_mid();
    test_loopback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
